axis_synchronizer_2: RTL and testbench

//  Rejoins two AXI-Stream branches (e.g. the outputs of axis_splitter_2 after independent processing) into one stream.
//  An output beat is the pair {input_0_data, input_1_data}; it is released only when both branches hold a beat.

---
 rtl/lcplc_axis_pkg.sv | 12 +
 rtl/axis_skid_buffer_2.sv | 73 +++++++
 rtl/axis_synchronizer_2.sv | 52 +++++
 tb/tb_axis_synchronizer_2.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lcplc_axis_pkg.sv
// Shared types for the AXI-Stream join path: skid buffer depth and occupancy states.
package lcplc_axis_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    SB_EMPTY,
    SB_HALF,
    SB_FULL
  } skid_state_t;

endpackage

// File: rtl/axis_skid_buffer_2.sv
// Two-entry skid buffer: registered ready, head slot exposed for an external pop.
//
// state    | meaning
// SB_EMPTY | no beat held, out_valid low
// SB_HALF  | one beat at head slot, still accepting
// SB_FULL  | both slots held, in_ready low
module axis_skid_buffer_2
  import lcplc_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  pop
);

  skid_state_t           state_q, state_d;
  logic                  head_q, head_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic                  push;
  logic                  do_pop;
  logic                  wr_slot;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    mem_d   = mem_q;
    push    = in_valid & ready_q;
    do_pop  = pop & (state_q != SB_EMPTY);
    // Tail sits one past the head only when a beat is already held.
    wr_slot = head_q ^ (state_q == SB_HALF);

    if (push) mem_d[wr_slot] = in_data;
    if (do_pop) head_d = ~head_q;

    case ({push, do_pop})
      2'b10:   state_d = (state_q == SB_EMPTY) ? SB_HALF : SB_FULL;
      2'b01:   state_d = (state_q == SB_FULL) ? SB_HALF : SB_EMPTY;
      default: state_d = state_q;
    endcase

    ready_d = (state_d != SB_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_EMPTY;
      head_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      ready_q <= ready_d;
    end
  end

  // Payload storage is left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = mem_q[head_q];

endmodule

// File: rtl/axis_synchronizer_2.sv
// Joins two AXI-Stream branches into one paired beat; each branch buffered independently.
module axis_synchronizer_2
  import lcplc_axis_pkg::*;
#(
  parameter int DATA_WIDTH_0 = 16,
  parameter int DATA_WIDTH_1 = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_0_valid,
  output logic                    input_0_ready,
  input  logic [DATA_WIDTH_0-1:0] input_0_data,
  input  logic                    input_1_valid,
  output logic                    input_1_ready,
  input  logic [DATA_WIDTH_1-1:0] input_1_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [DATA_WIDTH_0-1:0] output_data_0,
  output logic [DATA_WIDTH_1-1:0] output_data_1
);

  logic valid_0;
  logic valid_1;
  logic pop;

  axis_skid_buffer_2 #(.DATA_WIDTH(DATA_WIDTH_0)) u_skid_0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (input_0_valid),
    .in_ready  (input_0_ready),
    .in_data   (input_0_data),
    .out_valid (valid_0),
    .out_data  (output_data_0),
    .pop       (pop)
  );

  axis_skid_buffer_2 #(.DATA_WIDTH(DATA_WIDTH_1)) u_skid_1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (input_1_valid),
    .in_ready  (input_1_ready),
    .in_data   (input_1_data),
    .out_valid (valid_1),
    .out_data  (output_data_1),
    .pop       (pop)
  );

  // Both heads leave together, so a pop is only legal when both branches hold a beat.
  assign output_valid = valid_0 & valid_1;
  assign pop          = output_valid & output_ready;

endmodule

// File: tb/tb_axis_synchronizer_2.sv
// Directed and randomized bench for axis_synchronizer_2 against a per-branch queue model.
module tb_axis_synchronizer_2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_ready;
  logic [15:0] in0_data;
  logic        in1_valid, in1_ready;
  logic [15:0] in1_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data_0, out_data_1;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        m_rdy0, m_rdy1;
  bit          rnd_data;
  int          cyc;
  int          pops;
  int          first_pop, last_pop;
  logic [15:0] last_pop0, last_pop1;

  always #5 clk = ~clk;

  axis_synchronizer_2 #(.DATA_WIDTH_0(16), .DATA_WIDTH_1(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_0_valid (in0_valid),
    .input_0_ready (in0_ready),
    .input_0_data  (in0_data),
    .input_1_valid (in1_valid),
    .input_1_ready (in1_ready),
    .input_1_data  (in1_data),
    .output_valid  (out_valid),
    .output_ready  (out_ready),
    .output_data_0 (out_data_0),
    .output_data_1 (out_data_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict transfers from the model, advance, then compare.
  task automatic tick();
    bit push0, push1, pop;
    push0 = in0_valid && m_rdy0 && !rst;
    push1 = in1_valid && m_rdy1 && !rst;
    pop   = (q0.size() > 0) && (q1.size() > 0) && out_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_rdy0 = 1'b0;
      m_rdy1 = 1'b0;
    end else begin
      if (pop) begin
        last_pop0 = q0.pop_front();
        last_pop1 = q1.pop_front();
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      if (push0) q0.push_back(in0_data);
      if (push1) q1.push_back(in1_data);
      m_rdy0 = (q0.size() != 2);
      m_rdy1 = (q1.size() != 2);
    end
    if (push0) in0_data = rnd_data ? 16'($urandom) : in0_data + 16'd1;
    if (push1) in1_data = rnd_data ? 16'($urandom) : in1_data + 16'd1;

    chk("out_valid", 32'(out_valid), 32'((q0.size() > 0) && (q1.size() > 0)));
    chk("ready_0", 32'(in0_ready), 32'(m_rdy0));
    chk("ready_1", 32'(in1_ready), 32'(m_rdy1));
    if ((q0.size() > 0) && (q1.size() > 0)) begin
      chk("data_0", 32'(out_data_0), 32'(q0[0]));
      chk("data_1", 32'(out_data_1), 32'(q1[0]));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = 16'h0001;
    in1_data  = 16'h0A01;
    out_ready = 1'b0;
    m_rdy0    = 1'b0;
    m_rdy1    = 1'b0;
    rnd_data  = 1'b0;
    cyc       = 0;
    pops      = 0;
    first_pop = 0;
    last_pop  = 0;

    // Reset held two cycles, readies rise on the first cycle after release.
    tick();
    tick();
    chk("rst_ready_0", 32'(in0_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready_0", 32'(in0_ready), 32'd1);
    chk("post_rst_ready_1", 32'(in1_ready), 32'd1);

    // Branch 0 alone fills its buffer; branch 1 then completes the first pair.
    in0_valid = 1'b1;
    tick();
    tick();
    chk("b0_full_ready", 32'(in0_ready), 32'd0);
    tick();
    chk("b0_alone_valid", 32'(out_valid), 32'd0);
    chk("b0_third_held", 32'(in0_data), 32'h0003);
    in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    chk("pair1_valid", 32'(out_valid), 32'd1);
    chk("pair1_d0", 32'(out_data_0), 32'h0001);
    chk("pair1_d1", 32'(out_data_1), 32'h0A01);
    out_ready = 1'b1;
    tick();
    chk("b0_ready_after_pop", 32'(in0_ready), 32'd1);
    tick();
    in0_valid = 1'b0;
    tick();

    // Clear leftovers, then stream 0..99 on both branches at full rate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    in0_data  = 16'd0;
    in1_data  = 16'd0;
    pops      = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 110; i++) begin
      in0_valid = (in0_data < 16'd100);
      in1_valid = (in1_data < 16'd100);
      tick();
    end
    chk("stream_pairs", 32'(pops), 32'd100);
    chk("stream_span", 32'(last_pop - first_pop), 32'd99);
    chk("stream_last", 32'({last_pop0, last_pop1}), 32'h0063_0063);

    // Continuous inputs against a consumer that stalls every other pair of cycles.
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      out_ready = ((i / 2) % 2) == 0;
      tick();
    end

    // Periodic branch enables with a random consumer, then fully random traffic.
    for (int i = 0; i < 80; i++) begin
      in0_valid = (i % 2) == 0;
      in1_valid = (i % 3) != 0;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rnd_data = 1'b1;
    for (int i = 0; i < 150; i++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rnd_data = 1'b0;

    // Fill both buffers, reset mid-flight, confirm only new beats emerge.
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 16'h1000;
    in1_data  = 16'h2000;
    for (int i = 0; i < 4; i++) tick();
    chk("full_ready_0", 32'(in0_ready), 32'd0);
    chk("full_ready_1", 32'(in1_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    in0_data  = 16'h5000;
    in1_data  = 16'h5000;
    out_ready = 1'b1;
    pops      = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pops == 1) chk("first_post_rst_pair", 32'({last_pop0, last_pop1}), 32'h5000_5000);
    end
    chk("post_rst_pairs", 32'(pops > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
